// File: rtl/window_linebuffer_if.sv
// window_linebuffer_if
//   Stream interface around the window generator.
//   Pixel side : in_valid / in_ready / in_pixel (one pixel per handshake).
//   Window side: out_valid / out_ready / out_window (K*K elements, flat).
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted.
//   master = pixel source / window consumer, slave = the window generator.
interface window_linebuffer_if #(
  parameter int PIX_W = 7,
  parameter int K     = 9
);
  logic                   in_valid;
  logic                   in_ready;
  logic [PIX_W-1:0]       in_pixel;
  logic                   out_valid;
  logic                   out_ready;
  logic [K*K*PIX_W-1:0]   out_window;
  logic                   frame_done;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, frame_done
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, frame_done
  );
endinterface

// File: rtl/window_linebuffer.sv
// window_linebuffer
//   Streaming KxK window generator for raster-order IMG_W x IMG_H images.
//   K-1 circular line buffers (depth IMG_W, addressed by column) cascade
//   older rows upward; a KxK register window shifts left on every accepted
//   pixel and takes a fresh rightmost column. out_valid flags positions
//   where the whole window lies inside the current frame.
// Ports:
//   i_clk  : clock, all state on rising edge
//   i_rst  : synchronous active-high reset
//   bus    : window_linebuffer_if.slave (pixel in, window out, frame_done)
//   Element e = out_window[e*PIX_W +: PIX_W], e = r*K + c, r=0 oldest row,
//   c=0 oldest column.
module window_linebuffer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 7,
  parameter int K     = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  window_linebuffer_if.slave   bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
  localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic                 r_out_valid;
  logic                 r_frame_done;
  logic [PIX_W-1:0]     r_lb  [0:K-2][0:IMG_W-1];
  logic [PIX_W-1:0]     r_win [0:K-1][0:K-1];

  logic                 w_accept;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_qual;
  logic [PIX_W-1:0]     w_col_new [0:K-1];
  logic [K*K*PIX_W-1:0] w_window;

  // Only combinational path from out_ready to in_ready.
  assign bus.in_ready   = !r_out_valid || bus.out_ready;
  assign w_accept       = bus.in_valid && bus.in_ready;
  assign w_col_last     = (r_col == COL_LAST);
  assign w_row_last     = (r_row == ROW_LAST);
  // Window is complete once K rows and K columns of this row are present.
  assign w_qual         = (r_row >= ROW_K1) && (r_col >= COL_K1);

  assign bus.out_valid  = r_out_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.out_window = w_window;

  // New rightmost window column: line-buffer taps at col (old data, read
  // before this cycle's write) with the incoming pixel at the bottom.
  always_comb begin
    for (int j = 0; j < K; j++) begin
      w_col_new[j] = '0;
    end
    for (int j = 0; j < K-1; j++) begin
      w_col_new[j] = r_lb[j][r_col];
    end
    w_col_new[K-1] = bus.in_pixel;
  end

  // Flatten the 2-D window register onto the output bus.
  always_comb begin
    w_window = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_window[(r*K + c)*PIX_W +: PIX_W] = r_win[r][c];
      end
    end
  end

  // Raster position of the next pixel to accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Window-valid flag and end-of-frame pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_col_last && w_row_last;
      if (w_accept) begin
        r_out_valid <= w_qual;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Line buffers: each row cascades one buffer upward at column col; the
  // youngest buffer stores the incoming pixel. Contents are never reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int j = 0; j < K-2; j++) begin
        r_lb[j][r_col] <= r_lb[j+1][r_col];
      end
      r_lb[K-2][r_col] <= bus.in_pixel;
    end
  end

  // Shift window left by one column and load the new rightmost column.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][K-1] <= w_col_new[r];
      end
    end
  end

endmodule
